// File: rtl/mem_responder_l7.sv
// Memory-side responder for the MemIntf protocol: word storage with byte strobes,
// accessed at accept time, with in-order responses after a fixed latency via a bounded queue.

package mem_responder_l7_pkg;
    typedef enum logic {
        MEM_MSG_READ  = 1'b0,
        MEM_MSG_WRITE = 1'b1
    } t_op;
endpackage

module mem_responder_l7
    import mem_responder_l7_pkg::*;
#(
    parameter int p_opaq_bits   = 8,
    parameter int p_num_words   = 256,
    parameter int p_latency     = 2,
    parameter int p_queue_depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  t_op                    req_op,
    input  logic [p_opaq_bits-1:0] req_opaque,
    input  logic [31:0]            req_addr,
    input  logic [3:0]             req_strb,
    input  logic [31:0]            req_data,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output t_op                    resp_op,
    output logic [p_opaq_bits-1:0] resp_opaque,
    output logic [31:0]            resp_addr,
    output logic [3:0]             resp_strb,
    output logic [31:0]            resp_data
);

    localparam int AW = (p_num_words > 1) ? $clog2(p_num_words) : 1;
    localparam int QW = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;
    localparam int CW = $clog2(p_queue_depth + 1);
    localparam int GW = (p_latency > 1) ? $clog2(p_latency) : 1;
    localparam int BW = 1 + p_opaq_bits + 32 + 4 + 32;
    localparam logic [CW-1:0] DEPTH    = CW'(p_queue_depth);
    localparam logic [GW-1:0] LAST_AGE = GW'(p_latency - 1);

    typedef struct packed {
        t_op                    op;
        logic [p_opaq_bits-1:0] opaque;
        logic [31:0]            addr;
        logic [3:0]             strb;
        logic [31:0]            data;
    } t_entry;

    logic [31:0]   mem [p_num_words];
    t_entry        entry_q [p_queue_depth];
    logic [GW-1:0] age_q [p_queue_depth];

    logic [QW-1:0] head_q, head_d;
    logic [QW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          reqXfer;
    logic          respXfer;
    logic [AW-1:0] wordIdx;
    logic          unusedAddrBits;
    t_entry        newEntry;
    t_entry        headEntry;

    logic          stall_q;
    logic [BW-1:0] stallBundle_q;
    logic [BW-1:0] reqBundle;

    function automatic logic [QW-1:0] ptrInc(input logic [QW-1:0] p);
        if (p_queue_depth == 1) return '0;
        return p + QW'(1);
    endfunction

    // Upper address bits alias and the byte offset is ignored.
    assign wordIdx        = req_addr[AW+1:2];
    assign unusedAddrBits = ^{req_addr[31:AW+2], req_addr[1:0]};

    assign req_rdy   = (count_q < DEPTH);
    assign reqXfer   = req_val & req_rdy;
    assign headEntry = entry_q[head_q];
    assign resp_val  = (count_q != '0) && (age_q[head_q] == LAST_AGE);
    assign respXfer  = resp_val & resp_rdy;

    assign resp_op     = headEntry.op;
    assign resp_opaque = headEntry.opaque;
    assign resp_addr   = headEntry.addr;
    assign resp_strb   = headEntry.strb;
    assign resp_data   = headEntry.data;

    // A write committed on the previous edge is already visible to this read.
    always_comb begin
        newEntry        = '0;
        newEntry.op     = req_op;
        newEntry.opaque = req_opaque;
        newEntry.addr   = req_addr;
        newEntry.strb   = req_strb;
        newEntry.data   = (req_op == MEM_MSG_READ) ? mem[wordIdx] : 32'h0;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (reqXfer) tail_d = ptrInc(tail_q);
        if (respXfer) head_d = ptrInc(head_q);
        if (reqXfer && !respXfer) begin
            count_d = count_q + CW'(1);
        end else if (!reqXfer && respXfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reqXfer && req_op == MEM_MSG_WRITE) begin
            for (int i = 0; i < 4; i++) begin
                if (req_strb[i]) mem[wordIdx][8*i +: 8] <= req_data[8*i +: 8];
            end
        end
    end

    // Payload and age need no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (reqXfer) entry_q[tail_q] <= newEntry;
        for (int i = 0; i < p_queue_depth; i++) begin
            if (reqXfer && tail_q == QW'(i)) begin
                age_q[i] <= '0;
            end else if (age_q[i] != LAST_AGE) begin
                age_q[i] <= age_q[i] + GW'(1);
            end
        end
    end

    assign reqBundle = {req_op, req_opaque, req_addr, req_strb, req_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q       <= 1'b0;
            stallBundle_q <= '0;
        end else begin
            stall_q       <= req_val & ~req_rdy;
            stallBundle_q <= reqBundle;
            if (req_val) begin
                assert (!$isunknown(req_op))
                    else $error("[mem_responder_l7] req_op unknown on a valid request");
            end
            if (stall_q) begin
                assert (req_val && reqBundle == stallBundle_q)
                    else $error("[mem_responder_l7] request changed while stalled");
            end
        end
    end

endmodule

// File: tb/tb_mem_responder_l7.sv
// Directed bench for mem_responder_l7: write/read, partial strobes, aliasing,
// back-pressure with a full queue, streaming and asynchronous reset mid-flight.

module tb_mem_responder_l7;
    import mem_responder_l7_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    t_op         req_op;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [3:0]  req_strb;
    logic [31:0] req_data;
    logic        resp_val;
    logic        resp_rdy;
    t_op         resp_op;
    logic [7:0]  resp_opaque;
    logic [31:0] resp_addr;
    logic [3:0]  resp_strb;
    logic [31:0] resp_data;

    int checks;
    int failures;
    logic sawResp;

    mem_responder_l7 #(
        .p_opaq_bits  (8),
        .p_num_words  (256),
        .p_latency    (2),
        .p_queue_depth(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_op     (req_op),
        .req_opaque (req_opaque),
        .req_addr   (req_addr),
        .req_strb   (req_strb),
        .req_data   (req_data),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_op    (resp_op),
        .resp_opaque(resp_opaque),
        .resp_addr  (resp_addr),
        .resp_strb  (resp_strb),
        .resp_data  (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            end
    endtask

    task automatic applyStimulus(input t_op op, input logic [7:0] opq, input logic [31:0] addr,
                                 input logic [3:0] strb, input logic [31:0] data);
        req_val    = 1'b1;
        req_op     = op;
        req_opaque = opq;
        req_addr   = addr;
        req_strb   = strb;
        req_data   = data;
        tick();
        req_val    = 1'b0;
    endtask

    task automatic expectResp(input string tag, input t_op op, input logic [7:0] opq,
                              input logic [31:0] data);
        int n;
        n = 0;
        while (resp_val !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checkOutput({tag, "_val"}, 32'(resp_val), 32'd1);
        checkOutput({tag, "_op"}, 32'(resp_op), 32'(op));
        checkOutput({tag, "_opaque"}, 32'(resp_opaque), 32'(opq));
        checkOutput({tag, "_data"}, resp_data, data);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_val    = 1'b0;
        req_op     = MEM_MSG_READ;
        req_opaque = '0;
        req_addr   = '0;
        req_strb   = '0;
        req_data   = '0;
        resp_rdy   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_resp_val", 32'(resp_val), 32'd0);
        checkOutput("reset_req_rdy", 32'(req_rdy), 32'd1);
        rst = 1'b0;
        tick();

        // Write then read the same word on consecutive cycles.
        req_val    = 1'b1;
        req_op     = MEM_MSG_WRITE;
        req_opaque = 8'h11;
        req_addr   = 32'h40;
        req_strb   = 4'hF;
        req_data   = 32'hDEADBEEF;
        tick();
        checkOutput("wr_early_val", 32'(resp_val), 32'd0);
        req_op     = MEM_MSG_READ;
        req_opaque = 8'h22;
        req_strb   = 4'h0;
        req_data   = 32'h0;
        tick();
        req_val = 1'b0;
        checkOutput("wr_val", 32'(resp_val), 32'd1);
        checkOutput("wr_op", 32'(resp_op), 32'(MEM_MSG_WRITE));
        checkOutput("wr_opaque", 32'(resp_opaque), 32'h11);
        checkOutput("wr_data", resp_data, 32'h0);
        checkOutput("wr_addr", resp_addr, 32'h40);
        tick();
        checkOutput("rd_val", 32'(resp_val), 32'd1);
        checkOutput("rd_op", 32'(resp_op), 32'(MEM_MSG_READ));
        checkOutput("rd_opaque", 32'(resp_opaque), 32'h22);
        checkOutput("rd_data", resp_data, 32'hDEADBEEF);
        tick();
        checkOutput("rd_done_val", 32'(resp_val), 32'd0);

        // Partial strobe on lane 1 through an unaligned address.
        applyStimulus(MEM_MSG_WRITE, 8'h33, 32'h41, 4'b0010, 32'h0000AB00);
        tick();
        checkOutput("pw_val", 32'(resp_val), 32'd1);
        checkOutput("pw_addr", resp_addr, 32'h41);
        checkOutput("pw_strb", 32'(resp_strb), 32'h2);
        checkOutput("pw_data", resp_data, 32'h0);
        tick();
        applyStimulus(MEM_MSG_READ, 8'h44, 32'h40, 4'h0, 32'h0);
        expectResp("pr", MEM_MSG_READ, 8'h44, 32'hDEADABEF);

        // Address aliasing modulo 1 KiB.
        applyStimulus(MEM_MSG_WRITE, 8'h55, 32'h000, 4'hF, 32'h12345678);
        expectResp("alias_wr", MEM_MSG_WRITE, 8'h55, 32'h0);
        applyStimulus(MEM_MSG_READ, 8'h56, 32'h400, 4'h0, 32'h0);
        expectResp("alias_rd", MEM_MSG_READ, 8'h56, 32'h12345678);

        // Fill the queue under back-pressure, then drain.
        resp_rdy = 1'b0;
        req_op   = MEM_MSG_READ;
        req_addr = 32'h40;
        req_strb = 4'h0;
        req_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            req_val    = 1'b1;
            req_opaque = 8'h60 + 8'(i);
            tick();
            checkOutput($sformatf("full_rdy%0d", i), 32'(req_rdy), (i < 3) ? 32'd1 : 32'd0);
        end
        req_opaque = 8'h64;
        tick();
        tick();
        checkOutput("full_stall_rdy", 32'(req_rdy), 32'd0);
        checkOutput("full_head_val", 32'(resp_val), 32'd1);
        checkOutput("full_head_opaque", 32'(resp_opaque), 32'h60);
        resp_rdy = 1'b1;
        tick();
        checkOutput("full_deq1_val", 32'(resp_val), 32'd1);
        checkOutput("full_deq1_opaque", 32'(resp_opaque), 32'h61);
        checkOutput("full_reopen_rdy", 32'(req_rdy), 32'd1);
        tick();
        req_val = 1'b0;
        for (int k = 2; k < 5; k++) begin
            checkOutput($sformatf("full_drain%0d_val", k), 32'(resp_val), 32'd1);
            checkOutput($sformatf("full_drain%0d_opaque", k), 32'(resp_opaque), 32'h60 + 32'(k));
            tick();
        end
        checkOutput("full_empty_val", 32'(resp_val), 32'd0);

        // Streaming: one request and one response per cycle.
        for (int k = 0; k < 19; k++) begin
            if (k < 16) begin
                req_val    = 1'b1;
                req_op     = MEM_MSG_READ;
                req_opaque = 8'(k);
                req_addr   = 32'h40;
            end else begin
                req_val = 1'b0;
            end
            if (k >= 2 && k < 18) begin
                checkOutput($sformatf("stream%0d_val", k - 2), 32'(resp_val), 32'd1);
                checkOutput($sformatf("stream%0d_opaque", k - 2), 32'(resp_opaque), 32'(k - 2));
            end
            if (k == 18) checkOutput("stream_end_val", 32'(resp_val), 32'd0);
            tick();
        end

        // Asynchronous reset with three requests outstanding.
        resp_rdy = 1'b0;
        applyStimulus(MEM_MSG_WRITE, 8'h70, 32'h80, 4'hF, 32'hCAFEF00D);
        applyStimulus(MEM_MSG_READ, 8'h71, 32'h80, 4'h0, 32'h0);
        applyStimulus(MEM_MSG_READ, 8'h72, 32'h40, 4'h0, 32'h0);
        tick();
        checkOutput("inflight_val", 32'(resp_val), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_val", 32'(resp_val), 32'd0);
        checkOutput("async_rst_rdy", 32'(req_rdy), 32'd1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        resp_rdy = 1'b1;
        sawResp  = 1'b0;
        repeat (6) begin
            tick();
            if (resp_val) sawResp = 1'b1;
        end
        checkOutput("rst_no_stale", 32'(sawResp), 32'd0);
        applyStimulus(MEM_MSG_READ, 8'h73, 32'h80, 4'h0, 32'h0);
        expectResp("rst_persist", MEM_MSG_READ, 8'h73, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
